// File: rtl/uart_avmm_driver.sv
// uart_avmm_driver
//   Avalon-MM initiator for the uart_core 8-bit register slave
//   (addr 0 TX data, addr 1 status {busy,ready}, addr 2 RX data).
//   Outgoing bytes are buffered in a TX FIFO and written only after a status
//   poll reports ready. An irq_i pulse schedules a read of the RX data
//   register. The received byte is pushed into an RX FIFO.
//
// Ports
//   clk_i, arst_n_i            clock, asynchronous active-low reset
//   tx_data_i/valid_i/ready_o  outgoing byte stream (ready = TX FIFO not full)
//   rx_data_o/valid_o/ready_i  received byte stream (first-word fall-through)
//   irq_i                      1-cycle RX-byte-complete pulse from uart_core
//   avm_*                      Avalon-MM initiator to uart_core
//   rx_overrun_o               sticky: a received byte was lost
//   ovr_cnt_o                  saturating overrun event count, present only
//                              when UART_DRV_OVR_CNT_EN is defined
//
// Build option
//   UART_DRV_OVR_CNT_EN  adds ovr_cnt_o and its counter

module uart_avmm_driver #(
    parameter int unsigned TX_DEPTH   = 8,
    parameter int unsigned RX_DEPTH   = 8,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned POLL_GAP   = 2
) (
    input  logic       clk_i,
    input  logic       arst_n_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    input  logic       irq_i,
    output logic [3:0] avm_address_o,
    output logic       avm_byteenable_o,
    output logic       avm_read_o,
    output logic       avm_write_o,
    output logic [7:0] avm_writedata_o,
    input  logic [7:0] avm_readdata_i,
`ifdef UART_DRV_OVR_CNT_EN
    output logic [7:0] ovr_cnt_o,
`endif
    output logic       rx_overrun_o
);

    localparam int unsigned TX_AW = $clog2(TX_DEPTH);
    localparam int unsigned RX_AW = $clog2(RX_DEPTH);
    localparam int unsigned GAP_W = (POLL_GAP < 1) ? 1 : $clog2(POLL_GAP + 1);

    localparam logic [TX_AW:0] TX_FULL_CNT = (TX_AW + 1)'(TX_DEPTH);
    localparam logic [RX_AW:0] RX_FULL_CNT = (RX_AW + 1)'(RX_DEPTH);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RX_RD     = 3'd1;
    localparam logic [2:0] S_RX_WAIT   = 3'd2;
    localparam logic [2:0] S_POLL_RD   = 3'd3;
    localparam logic [2:0] S_POLL_WAIT = 3'd4;
    localparam logic [2:0] S_TX_WR     = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [1:0]       lat_q;
    logic             lat_done;
    logic [GAP_W-1:0] gap_q;
    logic             rx_pend_q;
    logic             overrun_q;
    logic             ovr_event;

    // TX FIFO
    logic [7:0]     tx_mem [TX_DEPTH];
    logic [TX_AW:0] tx_wptr, tx_rptr;
    logic           tx_empty, tx_full, tx_push, tx_pop;

    // RX FIFO
    logic [7:0]     rx_mem [RX_DEPTH];
    logic [RX_AW:0] rx_wptr, rx_rptr;
    logic           rx_empty, rx_full, rx_push, rx_pop;

    assign tx_empty = (tx_wptr == tx_rptr);
    assign tx_full  = ((tx_wptr - tx_rptr) == TX_FULL_CNT);
    assign tx_push  = tx_valid_i && !tx_full;
    assign tx_pop   = (state_q == S_TX_WR);

    assign rx_empty = (rx_wptr == rx_rptr);
    assign rx_full  = ((rx_wptr - rx_rptr) == RX_FULL_CNT);
    assign rx_pop   = rx_ready_i && !rx_empty;

    assign lat_done = (lat_q == 2'(RD_LATENCY));
    assign rx_push  = (state_q == S_RX_WAIT) && lat_done;

    always_ff @(posedge clk_i) begin
        if (tx_push) begin
            tx_mem[tx_wptr[TX_AW-1:0]] <= tx_data_i;
        end
        if (rx_push) begin
            rx_mem[rx_wptr[RX_AW-1:0]] <= avm_readdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
            rx_wptr <= '0;
            rx_rptr <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
            if (rx_push) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
        end
    end

    assign tx_ready_o = !tx_full;
    assign rx_valid_o = !rx_empty;
    assign rx_data_o  = rx_empty ? '0 : rx_mem[rx_rptr[RX_AW-1:0]];

    // RX has priority over TX. The RX read is held off while the RX FIFO is
    // full so a captured byte always has a slot.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (rx_pend_q && !rx_full) begin
                    state_d = S_RX_RD;
                end else if (!tx_empty && (gap_q == '0)) begin
                    state_d = S_POLL_RD;
                end
            end
            S_RX_RD:     state_d = S_RX_WAIT;
            S_RX_WAIT:   if (lat_done) state_d = S_IDLE;
            S_POLL_RD:   state_d = S_POLL_WAIT;
            S_POLL_WAIT: if (lat_done) state_d = avm_readdata_i[0] ? S_TX_WR : S_IDLE;
            S_TX_WR:     state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // lat_q counts cycles since the read strobe; 1 on the first wait cycle.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= S_IDLE;
            lat_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == S_RX_RD) || (state_q == S_POLL_RD)) begin
                lat_q <= 2'd1;
            end else if ((state_q == S_RX_WAIT) || (state_q == S_POLL_WAIT)) begin
                lat_q <= lat_q + 2'd1;
            end
            if (tx_pop) begin
                gap_q <= GAP_W'(POLL_GAP);
            end else if (gap_q != '0) begin
                gap_q <= gap_q - 1'b1;
            end
        end
    end

    // A second irq while a byte is still pending loses the earlier byte. In
    // RX_RD the pending byte is being read, so an irq there only re-arms
    // rx_pend (set wins over clear) and is not an overrun.
    assign ovr_event = irq_i && rx_pend_q && (state_q != S_RX_RD);

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            rx_pend_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (irq_i) begin
                rx_pend_q <= 1'b1;
            end else if (state_q == S_RX_RD) begin
                rx_pend_q <= 1'b0;
            end
            if (ovr_event) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign rx_overrun_o = overrun_q;

`ifdef UART_DRV_OVR_CNT_EN
    logic [7:0] ovr_cnt_q;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            ovr_cnt_q <= '0;
        end else if (ovr_event && (ovr_cnt_q != '1)) begin
            ovr_cnt_q <= ovr_cnt_q + 8'd1;
        end
    end

    assign ovr_cnt_o = ovr_cnt_q;
`endif

    // Bus outputs decode directly from the state register. Strobes therefore
    // drop with the asynchronous reset, and the address stays stable through
    // the wait states.
    always_comb begin
        avm_address_o   = '0;
        avm_read_o      = 1'b0;
        avm_write_o     = 1'b0;
        avm_writedata_o = '0;
        case (state_q)
            S_RX_RD: begin
                avm_address_o = 4'd2;
                avm_read_o    = 1'b1;
            end
            S_RX_WAIT: avm_address_o = 4'd2;
            S_POLL_RD: begin
                avm_address_o = 4'd1;
                avm_read_o    = 1'b1;
            end
            S_POLL_WAIT: avm_address_o = 4'd1;
            S_TX_WR: begin
                avm_address_o   = 4'd0;
                avm_write_o     = 1'b1;
                avm_writedata_o = tx_mem[tx_rptr[TX_AW-1:0]];
            end
            default: ;
        endcase
    end

    assign avm_byteenable_o = 1'b1;

endmodule

// File: tb/tb_uart_avmm_driver.sv
// tb_uart_avmm_driver
//   Self-checking bench for uart_avmm_driver. A behavioural uart_core register
//   slave answers reads exactly RD_LATENCY cycles after the strobe and returns
//   0xEE at any other time. Expected TX writes and RX bytes are queued when
//   stimulus is driven, then compared when the DUT produces them.
//   Ports: none (top-level bench).

module tb_uart_avmm_driver;

    localparam int unsigned RDL = 1;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       irq = 1'b0;
    logic [3:0] avm_address;
    logic       avm_byteenable;
    logic       avm_read;
    logic       avm_write;
    logic [7:0] avm_writedata;
    logic [7:0] avm_readdata = 8'hEE;
    logic       rx_overrun;
`ifdef UART_DRV_OVR_CNT_EN
    logic [7:0] ovr_cnt;
`endif

    uart_avmm_driver #(
        .TX_DEPTH  (8),
        .RX_DEPTH  (8),
        .RD_LATENCY(RDL),
        .POLL_GAP  (2)
    ) dut (
        .clk_i           (clk),
        .arst_n_i        (arst_n),
        .tx_data_i       (tx_data),
        .tx_valid_i      (tx_valid),
        .tx_ready_o      (tx_ready),
        .rx_data_o       (rx_data),
        .rx_valid_o      (rx_valid),
        .rx_ready_i      (rx_ready),
        .irq_i           (irq),
        .avm_address_o   (avm_address),
        .avm_byteenable_o(avm_byteenable),
        .avm_read_o      (avm_read),
        .avm_write_o     (avm_write),
        .avm_writedata_o (avm_writedata),
        .avm_readdata_i  (avm_readdata),
`ifdef UART_DRV_OVR_CNT_EN
        .ovr_cnt_o       (ovr_cnt),
`endif
        .rx_overrun_o    (rx_overrun)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Scoreboard queues and slave model state
    logic [7:0]  exp_tx[$];
    logic [7:0]  exp_rx[$];
    logic [3:0]  rd_log[$];
    logic [7:0]  uart_rx_reg = '0;
    int          busy_polls = 0;
    int          rd_cnt = 0;
    logic [3:0]  rd_addr = '0;
    logic        last_poll_ready = 1'b0;
    int unsigned cyc = 0;
    int unsigned last_poll_cyc = 0;
    int unsigned rd_total = 0;
    int unsigned rd2_total = 0;
    int unsigned wr_total = 0;

    always @(posedge clk) cyc++;

    // Slave read data: valid only during the cycle RDL cycles after the strobe.
    always @(posedge clk) begin
        #1;
        if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
                if (rd_addr == 4'd2) begin
                    avm_readdata = uart_rx_reg;
                end else if (rd_addr == 4'd1) begin
                    if (busy_polls > 0) begin
                        busy_polls--;
                        avm_readdata = 8'h00;
                    end else begin
                        avm_readdata = 8'h01;
                    end
                    last_poll_ready = avm_readdata[0];
                end else begin
                    avm_readdata = 8'hEE;
                end
            end else begin
                avm_readdata = 8'hEE;
            end
        end else begin
            avm_readdata = 8'hEE;
        end
    end

    // Bus and RX stream monitor
    always @(negedge clk) begin
        if (avm_read) begin
            rd_total++;
            rd_log.push_back(avm_address);
            if (avm_address == 4'd2) rd2_total++;
            if (avm_address == 4'd1) last_poll_cyc = cyc;
            rd_addr = avm_address;
            rd_cnt  = RDL;
        end
        if (avm_write) begin
            wr_total++;
            check("wr_addr", avm_address, 4'd0);
            check("wr_no_rd", avm_read, 1'b0);
            check("wr_after_ready_poll", last_poll_ready, 1'b1);
            check("wr_poll_spacing", cyc - last_poll_cyc, RDL + 1);
            if (exp_tx.size() == 0) check("wr_unexpected", 1, 0);
            else check("wr_data", avm_writedata, exp_tx.pop_front());
            last_poll_ready = 1'b0;
        end
        if (rx_valid && rx_ready) begin
            if (exp_rx.size() == 0) check("rx_unexpected", 1, 0);
            else check("rx_data", rx_data, exp_rx.pop_front());
        end
    end

    task automatic push_tx(input logic [7:0] b, input bit expect_wr);
        int n = 0;
        while (!tx_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        tx_data  = b;
        tx_valid = 1'b1;
        if (expect_wr) exp_tx.push_back(b);
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    task automatic send_irq(input logic [7:0] b, input bit expect_rx);
        @(posedge clk); #1;
        uart_rx_reg = b;
        irq = 1'b1;
        if (expect_rx) exp_rx.push_back(b);
        @(posedge clk); #1;
        irq = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_tx.size() != 0 || exp_rx.size() != 0) && n < 400) begin
            @(negedge clk); n++;
        end
        check(tag, exp_tx.size() + exp_rx.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned r0, w0, r2;
        int n;

        // Reset state
        #23;
        check("rst_read", avm_read, 0);
        check("rst_write", avm_write, 0);
        check("rst_addr", avm_address, 0);
        check("rst_wdata", avm_writedata, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_overrun", rx_overrun, 0);
        @(negedge clk);
        arst_n = 1'b1;

        // Idle: no strobes for 100 cycles
        repeat (100) @(negedge clk);
        check("idle_strobes", rd_total + wr_total, 0);
        check("idle_tx_ready", tx_ready, 1);
        check("idle_rx_valid", rx_valid, 0);

        // Single byte, status immediately ready
        w0 = wr_total;
        push_tx(8'h48, 1);
        wait_drain("tx_single_drain");
        repeat (20) @(negedge clk);
        check("tx_single_count", wr_total - w0, 1);

        // Two bytes, status busy for three polls
        busy_polls = 3;
        w0 = wr_total;
        push_tx(8'h41, 1);
        push_tx(8'h42, 1);
        wait_drain("tx_busy_drain");
        repeat (20) @(negedge clk);
        check("tx_busy_count", wr_total - w0, 2);

        // One received byte, held until accepted
        send_irq(8'h5A, 1);
        n = 0;
        while (!rx_valid && n < 50) begin
            @(negedge clk); n++;
        end
        check("rx_valid_seen", rx_valid, 1);
        check("rx_head", rx_data, 8'h5A);
        repeat (20) @(negedge clk);
        check("rx_hold_valid", rx_valid, 1);
        check("rx_hold_data", rx_data, 8'h5A);
        @(posedge clk); #1;
        rx_ready = 1'b1;
        wait_drain("rx_single_drain");
        @(posedge clk); #1;
        rx_ready = 1'b0;

        // Fill RX FIFO, then two more irqs: stall, then overrun
        r2 = rd2_total;
        for (int i = 0; i < 8; i++) begin
            send_irq(8'h10 + 8'(i), 1);
            repeat (8) @(posedge clk);
        end
        send_irq(8'h18, 0);
        repeat (10) @(negedge clk);
        check("ovr_not_yet", rx_overrun, 0);
        send_irq(8'h19, 1);
        repeat (10) @(negedge clk);
        check("full_no_rd", rd2_total - r2, 8);
        check("ovr_set", rx_overrun, 1);
`ifdef UART_DRV_OVR_CNT_EN
        check("ovr_cnt", ovr_cnt, 1);
`endif
        @(posedge clk); #1;
        rx_ready = 1'b1;
        wait_drain("rx_full_drain");
        check("full_rd_total", rd2_total - r2, 9);

        // RX takes priority over a simultaneously pending TX byte
        repeat (10) @(posedge clk);
        #1;
        rd_log.delete();
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        exp_tx.push_back(8'h55);
        uart_rx_reg = 8'h66;
        irq = 1'b1;
        exp_rx.push_back(8'h66);
        @(posedge clk); #1;
        tx_valid = 1'b0;
        irq = 1'b0;
        wait_drain("prio_drain");
        if (rd_log.size() >= 2) begin
            check("prio_first_rd", rd_log[0], 4'd2);
            check("prio_second_rd", rd_log[1], 4'd1);
        end else begin
            check("prio_rd_log_len", rd_log.size(), 2);
        end

        // Asynchronous reset during POLL_WAIT
        busy_polls = 1000;
        push_tx(8'h77, 0);
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!(avm_read && avm_address == 4'd1) && n < 100);
        check("poll_seen", n < 100, 1);
        @(posedge clk); #2;
        arst_n = 1'b0;
        #1;
        check("arst_read", avm_read, 0);
        check("arst_write", avm_write, 0);
        check("arst_addr", avm_address, 0);
        check("arst_tx_ready", tx_ready, 1);
        check("arst_overrun", rx_overrun, 0);
        rd_cnt = 0;
        busy_polls = 0;
        @(negedge clk);
        arst_n = 1'b1;
        r0 = rd_total;
        w0 = wr_total;
        repeat (50) @(negedge clk);
        check("arst_fifo_empty_rd", rd_total - r0, 0);
        check("arst_fifo_empty_wr", wr_total - w0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
